// File: rtl/tdc_frame_sequencer.sv
// Captures first-photon TDC stamps per pixel into ping-pong banks and serialises each
// closed acquisition as PIXEL_NUM words (pixel 0 first) for the histogram builder.
module tdc_frame_sequencer #(
  parameter int NP        = 10,
  parameter int PIXEL_NUM = 6,
  parameter int ACQ_NUM   = 2,
  localparam int PW = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1,
  localparam int AW = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    acq_start,
  input  logic                    acq_end,
  input  logic [PIXEL_NUM-1:0]    tdc_valid,
  input  logic [PIXEL_NUM*NP-1:0] tdc_data,
  output logic                    wrEn,
  output logic [NP-1:0]           data,
  output logic [PW-1:0]           pixel_idx,
  output logic [AW-1:0]           acq_idx,
  output logic                    frame_done,
  output logic                    overflow,
  output logic                    busy
);

  localparam logic [NP-1:0] NO_HIT   = '1;
  localparam logic [1:0]    S_IDLE   = 2'd0;
  localparam logic [1:0]    S_LOAD   = 2'd1;
  localparam logic [1:0]    S_EMIT   = 2'd2;
  localparam logic [PW-1:0] LAST_PIX = PW'(PIXEL_NUM - 1);
  localparam logic [AW-1:0] LAST_ACQ = AW'(ACQ_NUM - 1);

  logic [1:0]           state;
  logic [NP-1:0]        bank_ts [2][PIXEL_NUM];
  logic [PIXEL_NUM-1:0] bank_hit [2];
  logic [1:0]           bank_full;
  logic [NP-1:0]        shadow [PIXEL_NUM];
  logic                 win_open;
  logic                 wsel;
  logic                 rsel;
  logic                 close_ok;
  logic                 close_ovf;
  logic                 clr_wbank;

  // A bank counts as occupied only until LOAD copies it into the drain register,
  // so the next window can close into it while the previous one is still streaming.
  assign close_ok  = win_open && acq_end && !bank_full[~wsel];
  assign close_ovf = win_open && acq_end && bank_full[~wsel];
  assign clr_wbank = close_ovf || (win_open && !acq_end && acq_start);
  assign busy      = (|bank_full) || (state != S_IDLE);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state      <= S_IDLE;
      bank_full  <= '0;
      win_open   <= 1'b0;
      wsel       <= 1'b0;
      rsel       <= 1'b0;
      wrEn       <= 1'b0;
      data       <= '0;
      pixel_idx  <= '0;
      acq_idx    <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        bank_hit[b] <= '0;
        for (int p = 0; p < PIXEL_NUM; p++) bank_ts[b][p] <= NO_HIT;
      end
      for (int p = 0; p < PIXEL_NUM; p++) shadow[p] <= NO_HIT;
    end else begin
      overflow   <= close_ovf;
      frame_done <= 1'b0;

      // Hits sampled together with acq_end still land in the closing bank.
      if (win_open) begin
        for (int p = 0; p < PIXEL_NUM; p++) begin
          if (tdc_valid[p] && !bank_hit[wsel][p]) begin
            bank_ts[wsel][p]  <= tdc_data[p*NP +: NP];
            bank_hit[wsel][p] <= 1'b1;
          end
        end
      end

      if (clr_wbank) begin
        bank_hit[wsel] <= '0;
        for (int p = 0; p < PIXEL_NUM; p++) bank_ts[wsel][p] <= NO_HIT;
      end

      if (close_ok) begin
        bank_full[wsel] <= 1'b1;
        wsel            <= ~wsel;
        win_open        <= acq_start;
      end else if (close_ovf) begin
        win_open <= 1'b0;
      end else if (acq_start) begin
        win_open <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (|bank_full) state <= S_LOAD;
        end
        S_LOAD: begin
          for (int p = 0; p < PIXEL_NUM; p++) begin
            shadow[p]     <= bank_hit[rsel][p] ? bank_ts[rsel][p] : NO_HIT;
            bank_ts[rsel][p] <= NO_HIT;
          end
          data            <= bank_hit[rsel][0] ? bank_ts[rsel][0] : NO_HIT;
          wrEn            <= 1'b1;
          pixel_idx       <= '0;
          bank_hit[rsel]  <= '0;
          bank_full[rsel] <= 1'b0;
          rsel            <= ~rsel;
          state           <= S_EMIT;
        end
        S_EMIT: begin
          if (pixel_idx == LAST_PIX) begin
            wrEn       <= 1'b0;
            data       <= '0;
            pixel_idx  <= '0;
            frame_done <= (acq_idx == LAST_ACQ);
            acq_idx    <= (acq_idx == LAST_ACQ) ? '0 : acq_idx + 1'b1;
            state      <= (|bank_full) ? S_LOAD : S_IDLE;
          end else begin
            pixel_idx <= pixel_idx + 1'b1;
            data      <= shadow[pixel_idx + 1'b1];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
